// File: rtl/binary_thr_pkg.sv
// Shared widths, limits, FSM encoding and clamp helper for the binarization threshold controller.
package binary_thr_pkg;
    localparam int CNT_W       = 20;
    localparam int SUM_W       = 30;
    localparam int THR_W       = 10;
    localparam int MAX_SUM     = 765;
    localparam int DEFAULT_THR = 384;
    localparam int HYST        = 6;

    localparam logic [THR_W-1:0] MAX_THR = THR_W'(MAX_SUM);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        CALC,
        APPLY
    } state_t;

    // Saturate a signed biased sum into the legal channel-sum range 0..765.
    function automatic logic [THR_W-1:0] clamp_sum(input logic signed [THR_W+1:0] v);
        if (v[THR_W+1])
            return '0;
        else if (v > $signed({2'b00, MAX_THR}))
            return MAX_THR;
        return v[THR_W-1:0];
    endfunction
endpackage

// File: rtl/seq_div.sv
// Unsigned restoring divider, one quotient bit per cycle; divide-by-zero yields all-ones.
// Latency: DVD_W cycles after start; done is high during the final iteration, quotient valid the cycle after.
// Backpressure: none; a start while busy restarts the divide.
module seq_div #(
    parameter int DVD_W = 30,
    parameter int DVS_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);
    localparam int CW = $clog2(DVD_W + 1);

    logic [DVD_W-1:0] quo;
    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] den;
    logic [CW-1:0]    steps;
    logic [DVS_W:0]   shifted;
    logic [DVS_W:0]   diff;
    logic             ge;

    assign shifted  = {rem, quo[DVD_W-1]};
    assign diff     = shifted - {1'b0, den};
    assign ge       = shifted >= {1'b0, den};
    assign done     = busy && (steps == CW'(1));
    assign quotient = quo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo   <= '0;
            rem   <= '0;
            den   <= '0;
            steps <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            quo   <= dividend;
            rem   <= '0;
            den   <= divisor;
            steps <= CW'(DVD_W);
            busy  <= 1'b1;
        end else if (busy) begin
            quo   <= {quo[DVD_W-2:0], ge};
            rem   <= ge ? diff[DVS_W-1:0] : shifted[DVS_W-1:0];
            steps <= steps - CW'(1);
            if (steps == CW'(1))
                busy <= 1'b0;
        end
    end
endmodule

// File: rtl/binary_threshold_ctrl.sv
// Per-frame adaptive binarization threshold: frame mean of channel sums plus offset, with hysteresis or manual override.
// Latency: thr_valid SUM_W+3 cycles after vsync rise (auto), 2 cycles (manual); late results commit at the next frame end.
// Backpressure: none; a frame end while a result is in flight is dropped and flagged on overrun.
module binary_threshold_ctrl #(
    parameter int CNT_W       = binary_thr_pkg::CNT_W,
    parameter int SUM_W       = binary_thr_pkg::SUM_W,
    parameter int DEFAULT_THR = binary_thr_pkg::DEFAULT_THR,
    parameter int HYST        = binary_thr_pkg::HYST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync_in,
    input  logic        href_in,
    input  logic [31:0] gray_data_in,
    input  logic        auto_en,
    input  logic [9:0]  manual_thr,
    input  logic [9:0]  offset,
    output logic [9:0]  thr_out,
    output logic        thr_valid,
    output logic [9:0]  mean_out,
    output logic        busy,
    output logic        overrun
);
    import binary_thr_pkg::*;

    state_t                  state, state_nxt;
    logic                    vs_d, frame_end;
    logic [THR_W-1:0]        pix_sum;
    logic [SUM_W-1:0]        acc;
    logic [CNT_W-1:0]        cnt;
    logic                    div_start, div_done;
    logic [SUM_W-1:0]        div_quo;
    logic                    mode_auto, cnt_zero, load_manual;
    logic [THR_W-1:0]        mean, cand, pend_thr, abs_diff;
    logic                    pend_vld, upd_due;
    logic signed [THR_W+1:0] biased;
    logic                    unused_bits;

    assign pix_sum   = THR_W'(gray_data_in[31:24]) + THR_W'(gray_data_in[23:16])
                     + THR_W'(gray_data_in[15:8]);
    assign frame_end = vsync_in & ~vs_d;
    assign mean      = div_quo[THR_W-1:0];
    assign biased    = $signed({2'b00, mean}) + $signed({{2{offset[THR_W-1]}}, offset});
    assign abs_diff  = (cand >= thr_out) ? cand - thr_out : thr_out - cand;
    assign upd_due   = mode_auto ? (abs_diff >= THR_W'(HYST)) : (cand != thr_out);
    assign unused_bits = ^{gray_data_in[7:0], div_quo[SUM_W-1:THR_W]};

    // vs_d resets high so a vsync already asserted at reset release is not taken as a frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= 1'b1;
            acc  <= '0;
            cnt  <= '0;
        end else begin
            vs_d <= vsync_in;
            if (frame_end) begin
                acc <= href_in ? SUM_W'(pix_sum) : '0;
                cnt <= href_in ? CNT_W'(1) : '0;
            end else if (href_in) begin
                acc <= acc + SUM_W'(pix_sum);
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    seq_div #(
        .DVD_W (SUM_W),
        .DVS_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (acc),
        .divisor  (cnt),
        .busy     (busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        div_start   = 1'b0;
        load_manual = 1'b0;
        case (state)
            IDLE: begin
                if (frame_end) begin
                    if (auto_en) begin
                        state_nxt = DIVIDE;
                        div_start = 1'b1;
                    end else begin
                        state_nxt   = APPLY;
                        load_manual = 1'b1;
                    end
                end
            end
            DIVIDE:  if (div_done) state_nxt = CALC;
            CALC:    state_nxt = cnt_zero ? IDLE : APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_out   <= THR_W'(DEFAULT_THR);
            thr_valid <= 1'b0;
            mean_out  <= '0;
            overrun   <= 1'b0;
            mode_auto <= 1'b1;
            cnt_zero  <= 1'b1;
            cand      <= '0;
            pend_vld  <= 1'b0;
            pend_thr  <= '0;
        end else begin
            thr_valid <= 1'b0;
            overrun   <= frame_end && (state != IDLE);
            if (frame_end && state == IDLE)
                mode_auto <= auto_en;
            if (div_start)
                cnt_zero <= (cnt == '0);
            if (load_manual)
                cand <= clamp_sum({2'b00, manual_thr});
            if (state == CALC && !cnt_zero) begin
                mean_out <= mean;
                cand     <= clamp_sum(biased);
            end
            // A result that missed its blanking window lands at the next frame end.
            if (frame_end && pend_vld) begin
                thr_out   <= pend_thr;
                thr_valid <= 1'b1;
                pend_vld  <= 1'b0;
            end
            if (state == APPLY && upd_due) begin
                if (vsync_in) begin
                    thr_out   <= cand;
                    thr_valid <= 1'b1;
                end else begin
                    pend_vld <= 1'b1;
                    pend_thr <= cand;
                end
            end
        end
    end
endmodule
